// File: rtl/image_sequencer.sv
// image_sequencer: feeds images and labels into cnn_top one at a time.
// For each image it burst-reads the pixel and label words into local buffers
// and presents them until the network signals softmax_done. It walks every
// image index for NUM_EPOCHS passes over the dataset.
// Requires INPUT_SIZE >= FCL_OUTPUT_DIM, because the label reads share the
// pixel read counter.
module image_sequencer #(
   parameter int WIDTH            = 48,
   parameter int INPUT_DIM_HEIGHT = 10,
   parameter int INPUT_DIM_WIDTH  = 10,
   parameter int FCL_OUTPUT_DIM   = 10,
   parameter int NUM_IMAGES       = 1000,
   parameter int NUM_EPOCHS       = 1,
   parameter int INPUT_SIZE       = INPUT_DIM_HEIGHT * INPUT_DIM_WIDTH,
   localparam int PAW = (NUM_IMAGES * INPUT_SIZE > 1) ? $clog2(NUM_IMAGES * INPUT_SIZE) : 1,
   localparam int LAW = (NUM_IMAGES * FCL_OUTPUT_DIM > 1) ? $clog2(NUM_IMAGES * FCL_OUTPUT_DIM) : 1,
   localparam int IW  = (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1,
   localparam int EW  = $clog2(NUM_EPOCHS + 1)
) (
   input  logic                                                         clk,
   input  logic                                                         reset,
   input  logic                                                         start,
   output logic                                                         img_rd_en,
   output logic [PAW-1:0]                                               img_rd_addr,
   input  logic [WIDTH-1:0]                                             img_rd_data,
   output logic                                                         lbl_rd_en,
   output logic [LAW-1:0]                                               lbl_rd_addr,
   input  logic [WIDTH-1:0]                                             lbl_rd_data,
   output logic [INPUT_DIM_HEIGHT-1:0][INPUT_DIM_WIDTH-1:0][WIDTH-1:0]  input_data,
   output logic [FCL_OUTPUT_DIM-1:0][WIDTH-1:0]                         input_labels,
   output logic [IW-1:0]                                                input_index,
   output logic                                                         data_valid,
   input  logic                                                         softmax_done,
   output logic [EW-1:0]                                                epoch,
   output logic                                                         busy,
   output logic                                                         all_done
);

   localparam int KW = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
   localparam int RW = (INPUT_DIM_HEIGHT > 1) ? $clog2(INPUT_DIM_HEIGHT) : 1;
   localparam int CW = (INPUT_DIM_WIDTH > 1) ? $clog2(INPUT_DIM_WIDTH) : 1;
   localparam int LW = (FCL_OUTPUT_DIM > 1) ? $clog2(FCL_OUTPUT_DIM) : 1;

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_PRESENT, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [KW-1:0]   k_q, k_d;
   logic [PAW-1:0]  pix_base_q, pix_base_d;
   logic [LAW-1:0]  lbl_base_q, lbl_base_d;
   logic [IW-1:0]   index_q, index_d;
   logic [EW-1:0]   epoch_q, epoch_d;

   // Capture side: one-cycle-delayed read strobes and buffer write pointers.
   logic            cap_pix_q, cap_lbl_q;
   logic [RW-1:0]   wr_row_q;
   logic [CW-1:0]   wr_col_q;
   logic [LW-1:0]   wr_lbl_q;
   logic            fetch_load;

   logic [INPUT_DIM_HEIGHT-1:0][INPUT_DIM_WIDTH-1:0][WIDTH-1:0] data_buf_q;
   logic [FCL_OUTPUT_DIM-1:0][WIDTH-1:0]                         lbl_buf_q;

   // Control state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         k_q        <= '0;
         pix_base_q <= '0;
         lbl_base_q <= '0;
         index_q    <= '0;
         epoch_q    <= '0;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         pix_base_q <= pix_base_d;
         lbl_base_q <= lbl_base_d;
         index_q    <= index_d;
         epoch_q    <= epoch_d;
      end
   end

   // Next-state logic: fetch counter, image index, epoch and base addresses.
   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      pix_base_d = pix_base_q;
      lbl_base_d = lbl_base_q;
      index_d    = index_q;
      epoch_d    = epoch_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d    = S_FETCH;
               k_d        = '0;
               pix_base_d = '0;
               lbl_base_d = '0;
               index_d    = '0;
               epoch_d    = '0;
            end
         end
         S_FETCH: begin
            if (k_q == KW'(INPUT_SIZE - 1)) begin
               state_d = S_DRAIN;
               k_d     = '0;
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         S_DRAIN: state_d = S_PRESENT;
         S_PRESENT: begin
            if (softmax_done) begin
               if (index_q == IW'(NUM_IMAGES - 1)) begin
                  if (epoch_q == EW'(NUM_EPOCHS - 1)) begin
                     state_d = S_DONE;
                  end else begin
                     state_d    = S_FETCH;
                     index_d    = '0;
                     pix_base_d = '0;
                     lbl_base_d = '0;
                     epoch_d    = epoch_q + EW'(1);
                  end
               end else begin
                  state_d    = S_FETCH;
                  index_d    = index_q + IW'(1);
                  pix_base_d = pix_base_q + PAW'(INPUT_SIZE);
                  lbl_base_d = lbl_base_q + LAW'(FCL_OUTPUT_DIM);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Read strobes and addresses; addresses are parked at 0 when not reading.
   always_comb begin
      img_rd_en   = (state_q == S_FETCH);
      lbl_rd_en   = (state_q == S_FETCH) && (32'(k_q) < FCL_OUTPUT_DIM);
      img_rd_addr = img_rd_en ? pix_base_q + PAW'(k_q) : '0;
      lbl_rd_addr = lbl_rd_en ? lbl_base_q + LAW'(k_q) : '0;
   end

   assign fetch_load = (state_q != S_FETCH) && (state_d == S_FETCH);

   // Write returned words into the buffers one cycle after each read strobe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cap_pix_q  <= 1'b0;
         cap_lbl_q  <= 1'b0;
         wr_row_q   <= '0;
         wr_col_q   <= '0;
         wr_lbl_q   <= '0;
         data_buf_q <= '0;
         lbl_buf_q  <= '0;
      end else begin
         cap_pix_q <= img_rd_en;
         cap_lbl_q <= lbl_rd_en;
         if (cap_pix_q) begin
            data_buf_q[wr_row_q][wr_col_q] <= img_rd_data;
            if (wr_col_q == CW'(INPUT_DIM_WIDTH - 1)) begin
               wr_col_q <= '0;
               wr_row_q <= wr_row_q + RW'(1);
            end else begin
               wr_col_q <= wr_col_q + CW'(1);
            end
         end
         if (cap_lbl_q) begin
            lbl_buf_q[wr_lbl_q] <= lbl_rd_data;
            wr_lbl_q            <= wr_lbl_q + LW'(1);
         end
         // A new burst always starts filling from row 0, column 0, label 0.
         if (fetch_load) begin
            wr_row_q <= '0;
            wr_col_q <= '0;
            wr_lbl_q <= '0;
         end
      end
   end

   assign input_data   = data_buf_q;
   assign input_labels = lbl_buf_q;
   assign input_index  = index_q;
   assign epoch        = epoch_q;
   assign data_valid   = (state_q == S_PRESENT);
   assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
   assign all_done     = (state_q == S_DONE);

endmodule

// File: doc/image_sequencer.md
Name: image_sequencer

Overview:
- Initiator side of the image/label feed into cnn_top.
- Walks image index 0..NUM_IMAGES-1 for NUM_EPOCHS epochs.
- Per image: burst-reads pixel and label words from two synchronous single-port memories into local buffers, then holds input_data/input_labels/input_index stable until the network pulses softmax_done, then advances to the next image.
- Sits between the image/label storage and cnn_top.

Parameters:
WIDTH, 48, word width of pixels and labels (signed)
INPUT_DIM_HEIGHT, 10, image rows
INPUT_DIM_WIDTH, 10, image columns
FCL_OUTPUT_DIM, 10, label words per image
NUM_IMAGES, 1000, images per epoch
NUM_EPOCHS, 1, passes over the dataset before all_done
INPUT_SIZE, INPUT_DIM_HEIGHT*INPUT_DIM_WIDTH, pixels per image (derived)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  one-cycle pulse; begins a run from index 0, epoch 0
img_rd_en  out  1  pixel memory read strobe
img_rd_addr  out  $clog2(NUM_IMAGES*INPUT_SIZE)  pixel word address
img_rd_data  in  WIDTH  pixel word, valid exactly 1 cycle after img_rd_en
lbl_rd_en  out  1  label memory read strobe
lbl_rd_addr  out  $clog2(NUM_IMAGES*FCL_OUTPUT_DIM)  label word address
lbl_rd_data  in  WIDTH  label word, valid 1 cycle after lbl_rd_en
input_data  out  WIDTH x [INPUT_DIM_HEIGHT][INPUT_DIM_WIDTH]  pixel buffer to cnn_top
input_labels  out  WIDTH x [FCL_OUTPUT_DIM]  label buffer to cnn_top
input_index  out  $clog2(NUM_IMAGES)  unsigned index of the presented image
data_valid  out  1  buffers hold a complete image; stable while high
softmax_done  in  1  one-cycle pulse from cnn_top: current image consumed
epoch  out  $clog2(NUM_EPOCHS+1)  current epoch count
busy  out  1  high in any state other than IDLE/DONE
all_done  out  1  high in DONE

Behaviour:
Reset values:
- All outputs, counters and buffers are 0.
- State is IDLE.
- Reset mid-operation drops img_rd_en/lbl_rd_en/data_valid immediately (async) and abandons the run.

State machine, states IDLE, FETCH, DRAIN, PRESENT, DONE:
- IDLE: outputs idle. start=1 -> FETCH with index 0, epoch 0, pixel base 0, label base 0.
- FETCH: runs INPUT_SIZE cycles, counter k=0..INPUT_SIZE-1.
  - img_rd_en=1, img_rd_addr=pix_base+k.
  - For k<FCL_OUTPUT_DIM: lbl_rd_en=1, lbl_rd_addr=lbl_base+k.
  - Data returned in cycle k+1 is written to input_data[k / INPUT_DIM_WIDTH][k % INPUT_DIM_WIDTH] and input_labels[k].
  - Row/column are tracked with counters, not divide/modulo.
  - After k=INPUT_SIZE-1 -> DRAIN.
- DRAIN: one cycle; no reads; captures the final pixel -> PRESENT.
- PRESENT: data_valid=1.
  - Buffers, input_index and epoch do not change.
  - On softmax_done=1: data_valid drops next cycle.
  - If index=NUM_IMAGES-1 and epoch=NUM_EPOCHS-1 -> DONE.
  - Else if index=NUM_IMAGES-1: index<=0, bases<=0, epoch<=epoch+1 -> FETCH.
  - Else: index+1, pix_base+=INPUT_SIZE, lbl_base+=FCL_OUTPUT_DIM -> FETCH.
- DONE: all_done=1; buffers keep the last image. start=1 -> same as start from IDLE.

Timing:
- start at edge t -> first reads in cycle t+1 -> data_valid high from edge t+INPUT_SIZE+2.
- softmax_done at edge p -> next image's first read in cycle p+1, data_valid high again at p+INPUT_SIZE+2.
- Requirement: INPUT_SIZE >= FCL_OUTPUT_DIM.

Arithmetic: base addresses are unsigned and advanced by addition only (no multiplier); they never exceed the last valid word address.

Ignored events:
- start in FETCH/DRAIN/PRESENT.
- softmax_done outside PRESENT.
- softmax_done and start together in PRESENT: softmax_done is honoured, start is ignored.

Test Plan:
(bench params: 2x2 image, FCL_OUTPUT_DIM=2, NUM_IMAGES=3, NUM_EPOCHS=2; pixel mem word a = 100+a, label mem word a = 200+a)
1. Reset then idle 10 cycles -> all outputs 0; no rd_en; busy=0.
2. start at cycle 0 -> img_rd_addr 0,1,2,3 on cycles 1-4; lbl_rd_addr 0,1 on cycles 1-2; data_valid=1 at cycle 6 with input_data={{100,101},{102,103}}, input_labels={200,201}, input_index=0.
3. Hold softmax_done low 20 cycles in PRESENT -> buffers and data_valid unchanged; then pulse softmax_done -> reads at pixel addr 4-7 and label addr 2-3; index=1, data {104..107}.
4. Six softmax_done pulses total -> index sequence 0,1,2,0,1,2; epoch 0->1 at the wrap; after the sixth pulse all_done=1, busy=0, and no further reads.
5. softmax_done pulsed during FETCH and start pulsed during PRESENT -> both ignored; sequence and addresses unchanged.
6. Assert reset in FETCH at k=2 -> rd_en drops asynchronously and all outputs are 0; a following start refetches index 0 from address 0.
